// File: rtl/uart_rx_os.sv
// Oversampling UART receiver: 16 s_tick samples per bit. It samples each bit
// at mid-bit and reports every frame with a one-clock done strobe and a framing-error flag.
module uart_rx_os #(
   parameter int DBIT    = 8,
   parameter int SB_TICK = 16,
   parameter int OS      = 16
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            rx,
   input  logic            s_tick,
   output logic [DBIT-1:0] dout,
   output logic            rx_done_tick,
   output logic            frame_err,
   output logic            rx_busy
);

   localparam int NW = (DBIT > 1) ? $clog2(DBIT) : 1;
   localparam logic [4:0]    MID_TICK  = 5'(OS / 2 - 1);
   localparam logic [4:0]    LAST_TICK = 5'(OS - 1);
   localparam logic [4:0]    STOP_LAST = 5'(SB_TICK - 1);
   localparam logic [NW-1:0] LAST_BIT  = NW'(DBIT - 1);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   state_t            state_q, state_d;
   logic [4:0]        s_q, s_d;
   logic [NW-1:0]     n_q, n_d;
   logic [DBIT-1:0]   b_q, b_d;
   logic [DBIT-1:0]   dout_q, dout_d;
   logic              ferr_q, ferr_d;
   logic              done_q, done_d;
   logic              busy_q;
   logic              rx_meta_q, rx_s_q;

   // Two-flop synchronizer, reset to the idle line level
   always_ff @(posedge clk) begin
      if (reset) begin
         rx_meta_q <= 1'b1;
         rx_s_q    <= 1'b1;
      end else begin
         rx_meta_q <= rx;
         rx_s_q    <= rx_meta_q;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         s_q     <= '0;
         n_q     <= '0;
         b_q     <= '0;
         dout_q  <= '0;
         ferr_q  <= 1'b0;
         done_q  <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         s_q     <= s_d;
         n_q     <= n_d;
         b_q     <= b_d;
         dout_q  <= dout_d;
         ferr_q  <= ferr_d;
         done_q  <= done_d;
         busy_q  <= (state_d != IDLE);
      end
   end

   always_comb begin
      state_d = state_q;
      s_d     = s_q;
      n_d     = n_q;
      b_d     = b_q;
      dout_d  = dout_q;
      ferr_d  = ferr_q;
      done_d  = 1'b0;
      case (state_q)
         IDLE: begin
            // Start detection runs every clock so back-to-back frames lose no time
            if (!rx_s_q) begin
               state_d = START;
               s_d     = '0;
            end
         end
         START: begin
            if (s_tick) begin
               if (s_q == MID_TICK) begin
                  if (!rx_s_q) begin
                     state_d = DATA;
                     s_d     = '0;
                     n_d     = '0;
                  end else begin
                     state_d = IDLE;
                  end
               end else begin
                  s_d = s_q + 5'd1;
               end
            end
         end
         DATA: begin
            if (s_tick) begin
               if (s_q == LAST_TICK) begin
                  s_d = '0;
                  b_d = {rx_s_q, b_q[DBIT-1:1]};
                  if (n_q == LAST_BIT) state_d = STOP;
                  else                 n_d = n_q + 1'b1;
               end else begin
                  s_d = s_q + 5'd1;
               end
            end
         end
         STOP: begin
            if (s_tick) begin
               if (s_q == STOP_LAST) begin
                  state_d = IDLE;
                  done_d  = 1'b1;
                  dout_d  = b_q;
                  ferr_d  = ~rx_s_q;
               end else begin
                  s_d = s_q + 5'd1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign dout         = dout_q;
   assign rx_done_tick = done_q;
   assign frame_err    = ferr_q;
   assign rx_busy      = busy_q;

endmodule

// File: tb/tb_uart_rx_os.sv
// Bench for uart_rx_os: frames are serialized in s_tick units and expected
// results travel through a scoreboard queue to the strobe monitor.
module tb_uart_rx_os;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       rx = 1'b1;
   logic       s_tick = 1'b0;
   logic [7:0] dout;
   logic       rx_done_tick;
   logic       frame_err;
   logic       rx_busy;

   logic       tick_en = 1'b1;
   int         tdiv = 0;
   int         cyc = 0;
   int         total = 0;
   int         bad = 0;
   logic [8:0] sb[$];
   int         done_cyc[$];
   logic       prev_done = 1'b0;

   uart_rx_os #(.DBIT(8), .SB_TICK(16), .OS(16)) dut (
      .clk          (clk),
      .reset        (reset),
      .rx           (rx),
      .s_tick       (s_tick),
      .dout         (dout),
      .rx_done_tick (rx_done_tick),
      .frame_err    (frame_err),
      .rx_busy      (rx_busy)
   );

   always #5 clk = ~clk;

   // Tick generator: one s_tick every 4 clocks, gated by tick_en
   initial begin
      forever begin
         @(posedge clk);
         cyc = cyc + 1;
         #1;
         if (tick_en) begin
            tdiv   = (tdiv + 1) % 4;
            s_tick = (tdiv == 0);
         end else begin
            s_tick = 1'b0;
         end
      end
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total = total + 1;
      if (got !== exp) begin
         bad = bad + 1;
         $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic wait_ticks(input int n);
      repeat (n) begin
         do @(posedge clk); while (s_tick !== 1'b1);
      end
   endtask

   task automatic put_rx(input logic v);
      #2 rx = v;
   endtask

   // stop_ok=0 drives the stop bit low for its first 12 ticks only, so the
   // line is back high before the receiver's next start-bit midpoint
   task automatic send_frame(input logic [7:0] d, input logic stop_ok);
      sb.push_back({~stop_ok, d});
      put_rx(1'b0);
      wait_ticks(16);
      for (int i = 0; i < 8; i++) begin
         put_rx(d[i]);
         wait_ticks(16);
      end
      if (stop_ok) begin
         put_rx(1'b1);
         wait_ticks(16);
      end else begin
         put_rx(1'b0);
         wait_ticks(12);
         put_rx(1'b1);
         wait_ticks(4);
      end
   endtask

   // Strobe monitor: pops the scoreboard on each rx_done_tick
   initial begin
      logic [8:0] e;
      forever begin
         @(negedge clk);
         if (rx_done_tick === 1'b1) begin
            if (prev_done === 1'b1) check_eq("double_strobe", 32'd1, 32'd0);
            done_cyc.push_back(cyc);
            if (sb.size() == 0) begin
               check_eq("unexpected_strobe", 32'd1, 32'd0);
            end else begin
               e = sb.pop_front();
               check_eq("dout", 32'(dout), 32'(e[7:0]));
               check_eq("frame_err", 32'(frame_err), 32'(e[8]));
               check_eq("busy_at_done", 32'(rx_busy), 32'd0);
            end
         end
         prev_done = rx_done_tick;
      end
   end

   initial begin
      repeat (60000) @(posedge clk);
      $display("FAIL watchdog: got=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int c0;
      repeat (3) @(posedge clk);
      #2 reset = 1'b0;
      @(negedge clk);
      check_eq("rst_dout", 32'(dout), 32'd0);
      check_eq("rst_done", 32'(rx_done_tick), 32'd0);
      check_eq("rst_ferr", 32'(frame_err), 32'd0);
      check_eq("rst_busy", 32'(rx_busy), 32'd0);
      wait_ticks(16);

      send_frame(8'hA5, 1'b1);
      wait_ticks(16);
      check_eq("a5_strobes", 32'(done_cyc.size()), 32'd1);

      // Short low pulse: must be rejected at the start-bit midpoint
      put_rx(1'b0);
      wait_ticks(3);
      put_rx(1'b1);
      wait_ticks(32);
      check_eq("glitch_strobes", 32'(done_cyc.size()), 32'd1);
      check_eq("glitch_dout", 32'(dout), 32'hA5);
      check_eq("glitch_busy", 32'(rx_busy), 32'd0);

      send_frame(8'h3C, 1'b0);
      wait_ticks(32);
      check_eq("ferr_held", 32'(frame_err), 32'd1);
      send_frame(8'h01, 1'b1);
      wait_ticks(16);
      check_eq("ferr_cleared", 32'(frame_err), 32'd0);

      c0 = done_cyc.size();
      send_frame(8'h00, 1'b1);
      send_frame(8'hFF, 1'b1);
      wait_ticks(16);
      check_eq("b2b_strobes", 32'(done_cyc.size()), 32'(c0 + 2));
      if (done_cyc.size() >= c0 + 2)
         check_eq("b2b_spacing", 32'(done_cyc[c0+1] - done_cyc[c0]), 32'd640);

      // Reset mid-frame, in the middle of data bit 4 of 0x55
      put_rx(1'b0);
      wait_ticks(16);
      for (int i = 0; i < 4; i++) begin
         put_rx(((8'h55 >> i) & 8'h01) != 0);
         wait_ticks(16);
      end
      put_rx(1'b1);
      wait_ticks(8);
      check_eq("busy_mid_frame", 32'(rx_busy), 32'd1);
      #2 reset = 1'b1;
      @(posedge clk);
      #2 reset = 1'b0;
      @(negedge clk);
      check_eq("midrst_dout", 32'(dout), 32'd0);
      check_eq("midrst_busy", 32'(rx_busy), 32'd0);
      check_eq("midrst_done", 32'(rx_done_tick), 32'd0);
      wait_ticks(40);
      check_eq("midrst_no_strobe", 32'(done_cyc.size()), 32'(c0 + 2));
      send_frame(8'h81, 1'b1);
      wait_ticks(16);

      // Tick stall of 100 clocks inside the data bits
      fork
         send_frame(8'hC3, 1'b1);
         begin
            wait_ticks(60);
            tick_en = 1'b0;
            repeat (100) @(posedge clk);
            tick_en = 1'b1;
         end
      join
      wait_ticks(16);

      check_eq("total_strobes", 32'(done_cyc.size()), 32'd7);
      check_eq("sb_empty", 32'(sb.size()), 32'd0);
      check_eq("final_dout", 32'(dout), 32'hC3);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
